mem_parity_lane: RTL and testbench

Parametrised successor to the team's 1k x 32 parity RAM: single-port synchronous memory with per-lane parity, byte-lane write enables and a registered read path. It adds error injection, first-error address capture and a saturating error counter, so system diagnostics can log parity faults. It is a drop-in storage macro for datapath buffers and register-file backing stores.

---
 rtl/mem_parity_lane_if.sv | 35 +++
 rtl/mem_parity_lane.sv | 128 ++++++++++++
 tb/tb_mem_parity_lane.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_parity_lane_if.sv
// Bus bundle for mem_parity_lane: request/write-data inputs and read/diagnostic outputs.
interface mem_parity_lane_if #(
  parameter int unsigned AddrWidth   = 10,
  parameter int unsigned MemWidth    = 32,
  parameter int unsigned LaneWidth   = 8,
  parameter int unsigned ErrCntWidth = 8
);
  localparam int unsigned Lanes = MemWidth / LaneWidth;

  logic                   ChipEn;
  logic                   Read;
  logic                   Write;
  logic [Lanes-1:0]       ByteEn;
  logic [AddrWidth-1:0]   Addr;
  logic [MemWidth-1:0]    DataI;
  logic                   InjErr;
  logic                   ErrClr;
  logic [MemWidth-1:0]    DataO;
  logic                   Valid;
  logic                   ParityErr;
  logic [Lanes-1:0]       ErrLane;
  logic [AddrWidth-1:0]   ErrAddr;
  logic [ErrCntWidth-1:0] ErrCnt;
  logic                   ErrOvf;

  modport master (
    output ChipEn, Read, Write, ByteEn, Addr, DataI, InjErr, ErrClr,
    input  DataO, Valid, ParityErr, ErrLane, ErrAddr, ErrCnt, ErrOvf
  );

  modport slave (
    input  ChipEn, Read, Write, ByteEn, Addr, DataI, InjErr, ErrClr,
    output DataO, Valid, ParityErr, ErrLane, ErrAddr, ErrCnt, ErrOvf
  );
endinterface

// File: rtl/mem_parity_lane.sv
// Single-port RAM with per-lane parity, byte-lane writes, registered read,
// parity error injection, first-error address capture and saturating error count.
module mem_parity_lane #(
  parameter int unsigned AddrWidth   = 10,
  parameter int unsigned MemWidth    = 32,
  parameter int unsigned LaneWidth   = 8,
  parameter int unsigned ErrCntWidth = 8,
  parameter bit          OddParity   = 1'b0
) (
  input logic              clk,
  input logic              rst,
  mem_parity_lane_if.slave bus
);
  localparam int unsigned Lanes = MemWidth / LaneWidth;
  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [MemWidth-1:0] data_mem [Depth];
  logic [Lanes-1:0]    par_mem  [Depth];

  logic [MemWidth-1:0]    data_q, data_d;
  logic                   valid_q, valid_d;
  logic [Lanes-1:0]       err_lane_q, err_lane_d;
  logic                   perr_q, perr_d;
  logic [AddrWidth-1:0]   err_addr_q, err_addr_d;
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic                   err_ovf_q, err_ovf_d;
  logic                   cap_q, cap_d;

  logic                   op_rd, op_wr, log_err;
  logic [MemWidth-1:0]    rd_data;
  logic [Lanes-1:0]       rd_par, lane_err, wr_par;
  logic [ErrCntWidth-1:0] cnt_base;
  logic                   ovf_base, cap_base;

  assign op_rd   = bus.ChipEn & bus.Read;
  assign op_wr   = bus.ChipEn & bus.Write & ~bus.Read;
  assign rd_data = data_mem[bus.Addr];
  assign rd_par  = par_mem[bus.Addr];

  always_comb begin
    wr_par   = '0;
    lane_err = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      wr_par[i]   = (^bus.DataI[i*LaneWidth +: LaneWidth]) ^ OddParity ^ bus.InjErr;
      lane_err[i] = (^{rd_par[i], rd_data[i*LaneWidth +: LaneWidth]}) != OddParity;
    end
  end

  assign log_err = op_rd & ~bus.Write & (|lane_err);

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    err_lane_d = err_lane_q;
    perr_d     = perr_q;
    if (op_rd) begin
      data_d     = rd_data;
      valid_d    = ~bus.Write;
      err_lane_d = bus.Write ? '0 : lane_err;
      perr_d     = bus.Write ? 1'b0 : (|lane_err);
    end else if (bus.ChipEn) begin
      valid_d = 1'b0;
    end
  end

  // Clear is applied first so a same-edge error is logged on top of the cleared state.
  always_comb begin
    cnt_base = bus.ErrClr ? '0 : err_cnt_q;
    ovf_base = bus.ErrClr ? 1'b0 : err_ovf_q;
    cap_base = bus.ErrClr ? 1'b0 : cap_q;
    err_cnt_d  = cnt_base;
    err_ovf_d  = ovf_base;
    cap_d      = cap_base;
    err_addr_d = bus.ErrClr ? '0 : err_addr_q;
    if (log_err) begin
      if (!cap_base) begin
        err_addr_d = bus.Addr;
        cap_d      = 1'b1;
      end
      if (cnt_base == '1) begin
        err_ovf_d = 1'b1;
      end else begin
        err_cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (op_wr) begin
      for (int unsigned i = 0; i < Lanes; i++) begin
        if (bus.ByteEn[i]) begin
          data_mem[bus.Addr][i*LaneWidth +: LaneWidth] <= bus.DataI[i*LaneWidth +: LaneWidth];
          par_mem[bus.Addr][i] <= wr_par[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_lane_q <= '0;
      perr_q     <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
      err_ovf_q  <= 1'b0;
      cap_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_lane_q <= err_lane_d;
      perr_q     <= perr_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
      err_ovf_q  <= err_ovf_d;
      cap_q      <= cap_d;
    end
  end

  assign bus.DataO     = bus.ChipEn ? data_q : '0;
  assign bus.Valid     = bus.ChipEn & valid_q;
  assign bus.ErrLane   = err_lane_q;
  assign bus.ParityErr = perr_q;
  assign bus.ErrAddr   = err_addr_q;
  assign bus.ErrCnt    = err_cnt_q;
  assign bus.ErrOvf    = err_ovf_q;
endmodule

// File: tb/tb_mem_parity_lane.sv
// Scoreboard bench for mem_parity_lane (ErrCntWidth=2 to reach saturation quickly).
module tb_mem_parity_lane;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  lane;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_data [int];
  logic [3:0]  m_par  [int];

  mem_parity_lane_if #(.AddrWidth(10), .MemWidth(32), .LaneWidth(8), .ErrCntWidth(2)) bus ();

  mem_parity_lane #(
    .AddrWidth(10), .MemWidth(32), .LaneWidth(8), .ErrCntWidth(2), .OddParity(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic go_idle();
    bus.Read = 1'b0; bus.Write = 1'b0; bus.InjErr = 1'b0; bus.ErrClr = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be, input bit inj);
    logic [31:0] md;
    logic [3:0]  mp;
    logic [7:0]  lane;
    @(negedge clk);
    bus.Write = 1'b1; bus.Read = 1'b0; bus.Addr = a; bus.DataI = d; bus.ByteEn = be; bus.InjErr = inj;
    @(posedge clk); #1;
    md = m_data.exists(int'(a)) ? m_data[int'(a)] : 32'h0;
    mp = m_par.exists(int'(a)) ? m_par[int'(a)] : 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        lane = d[i*8 +: 8];
        md[i*8 +: 8] = lane;
        mp[i] = (^lane) ^ inj;
      end
    end
    m_data[int'(a)] = md;
    m_par[int'(a)]  = mp;
    go_idle();
  endtask

  // Drives one read for a cycle and pushes the model's expectation.
  task automatic rd(input logic [9:0] a, input bit clr);
    exp_t       e;
    logic [7:0] lane;
    @(negedge clk);
    bus.Read = 1'b1; bus.Write = 1'b0; bus.Addr = a; bus.ErrClr = clr;
    e.data = m_data[int'(a)];
    for (int i = 0; i < 4; i++) begin
      lane = e.data[i*8 +: 8];
      e.lane[i] = (^lane) ^ m_par[int'(a)][i];
    end
    sb.push_back(e);
    @(posedge clk); #1;
    go_idle();
  endtask

  task automatic test_reset();
    bus.ChipEn = 1'b1; bus.ByteEn = 4'h0; bus.Addr = '0; bus.DataI = '0;
    go_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.DataO !== 32'h0) begin fails++; $display("FAIL reset_datao got=%h exp=0", bus.DataO); end
    checks++; if (bus.Valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus.Valid); end
    checks++; if (bus.ErrLane !== 4'h0 || bus.ParityErr !== 1'b0) begin fails++; $display("FAIL reset_err got=%h/%b exp=0/0", bus.ErrLane, bus.ParityErr); end
    checks++; if (bus.ErrCnt !== 2'd0 || bus.ErrOvf !== 1'b0 || bus.ErrAddr !== 10'h0) begin
      fails++; $display("FAIL reset_log got=%0d/%b/%h exp=0/0/0", bus.ErrCnt, bus.ErrOvf, bus.ErrAddr); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_word();
    exp_t e;
    wr(10'h005, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(10'h005, 1'b0);
    e = sb.pop_front();
    checks++; if (bus.Valid !== 1'b1) begin fails++; $display("FAIL fw_valid got=%b exp=1", bus.Valid); end
    checks++; if (bus.DataO !== e.data) begin fails++; $display("FAIL fw_data got=%h exp=%h", bus.DataO, e.data); end
    checks++; if (bus.ParityErr !== 1'b0 || bus.ErrLane !== e.lane || bus.ErrCnt !== 2'd0) begin
      fails++; $display("FAIL fw_err got=%b/%h/%0d exp=0/%h/0", bus.ParityErr, bus.ErrLane, bus.ErrCnt, e.lane); end
    @(posedge clk); #1;
    checks++; if (bus.Valid !== 1'b0 || bus.DataO !== 32'hDEADBEEF) begin
      fails++; $display("FAIL fw_hold got=%b/%h exp=0/deadbeef", bus.Valid, bus.DataO); end
  endtask

  task automatic test_byte_en();
    exp_t e;
    wr(10'h010, 32'h11223344, 4'hF, 1'b0);
    wr(10'h010, 32'hAABBCCDD, 4'h5, 1'b0);
    rd(10'h010, 1'b0);
    e = sb.pop_front();
    checks++; if (bus.Valid !== 1'b1 || bus.DataO !== e.data) begin
      fails++; $display("FAIL be_data got=%b/%h exp=1/%h", bus.Valid, bus.DataO, e.data); end
    checks++; if (bus.DataO !== 32'h11BB33DD || bus.ParityErr !== 1'b0) begin
      fails++; $display("FAIL be_const got=%h/%b exp=11bb33dd/0", bus.DataO, bus.ParityErr); end
  endtask

  task automatic test_inject();
    exp_t e;
    wr(10'h3FF, 32'h0, 4'hF, 1'b0);
    wr(10'h3FF, 32'h0, 4'h2, 1'b1);
    rd(10'h3FF, 1'b0);
    e = sb.pop_front();
    checks++; if (bus.ErrLane !== e.lane || bus.ErrLane !== 4'h2 || bus.ParityErr !== 1'b1) begin
      fails++; $display("FAIL inj_lane got=%h/%b exp=%h/1", bus.ErrLane, bus.ParityErr, e.lane); end
    checks++; if (bus.ErrAddr !== 10'h3FF || bus.ErrCnt !== 2'd1) begin
      fails++; $display("FAIL inj_log1 got=%h/%0d exp=3ff/1", bus.ErrAddr, bus.ErrCnt); end
    rd(10'h3FF, 1'b0);
    e = sb.pop_front();
    checks++; if (bus.ErrAddr !== 10'h3FF || bus.ErrCnt !== 2'd2 || bus.DataO !== e.data) begin
      fails++; $display("FAIL inj_log2 got=%h/%0d/%h exp=3ff/2/%h", bus.ErrAddr, bus.ErrCnt, bus.DataO, e.data); end
    @(negedge clk); bus.ErrClr = 1'b1;
    @(posedge clk); #1; bus.ErrClr = 1'b0;
    checks++; if (bus.ErrAddr !== 10'h0 || bus.ErrCnt !== 2'd0 || bus.ErrOvf !== 1'b0) begin
      fails++; $display("FAIL inj_clr got=%h/%0d/%b exp=0/0/0", bus.ErrAddr, bus.ErrCnt, bus.ErrOvf); end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int k = 1; k <= 5; k++) begin
      rd(10'h3FF, 1'b0);
      e = sb.pop_front();
      checks++;
      if (bus.ErrCnt !== ((k >= 3) ? 2'd3 : 2'(k)) || bus.ErrOvf !== (k >= 4) || bus.ParityErr !== 1'b1) begin
        fails++; $display("FAIL sat_read%0d got=%0d/%b/%b exp=%0d/%b/1", k, bus.ErrCnt, bus.ErrOvf,
                          bus.ParityErr, (k >= 3) ? 3 : k, k >= 4);
      end
    end
    rd(10'h3FF, 1'b1);
    e = sb.pop_front();
    checks++; if (bus.ErrCnt !== 2'd1 || bus.ErrOvf !== 1'b0 || bus.ErrAddr !== 10'h3FF || bus.ErrLane !== e.lane) begin
      fails++; $display("FAIL sat_clr_win got=%0d/%b/%h/%h exp=1/0/3ff/%h", bus.ErrCnt, bus.ErrOvf, bus.ErrAddr, bus.ErrLane, e.lane); end
  endtask

  task automatic test_rw_conflict();
    exp_t e;
    @(negedge clk);
    bus.Read = 1'b1; bus.Write = 1'b1; bus.Addr = 10'h005; bus.DataI = 32'h0; bus.ByteEn = 4'hF;
    @(posedge clk); #1;
    go_idle();
    checks++; if (bus.Valid !== 1'b0 || bus.DataO !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rw_out got=%b/%h exp=0/deadbeef", bus.Valid, bus.DataO); end
    checks++; if (bus.ErrLane !== 4'h0 || bus.ParityErr !== 1'b0 || bus.ErrCnt !== 2'd1) begin
      fails++; $display("FAIL rw_err got=%h/%b/%0d exp=0/0/1", bus.ErrLane, bus.ParityErr, bus.ErrCnt); end
    rd(10'h005, 1'b0);
    e = sb.pop_front();
    checks++; if (bus.Valid !== 1'b1 || bus.DataO !== e.data || bus.DataO !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rw_after got=%b/%h exp=1/deadbeef", bus.Valid, bus.DataO); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] addrs [3];
    exp_t       e;
    logic [7:0] lane;
    addrs[0] = 10'h005; addrs[1] = 10'h010; addrs[2] = 10'h005;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.Read = 1'b1; bus.Addr = addrs[n];
      e.data = m_data[int'(addrs[n])];
      for (int i = 0; i < 4; i++) begin
        lane = e.data[i*8 +: 8];
        e.lane[i] = (^lane) ^ m_par[int'(addrs[n])][i];
      end
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (bus.Valid !== 1'b1 || bus.DataO !== e.data || bus.ErrLane !== e.lane) begin
        fails++; $display("FAIL b2b_%0d got=%b/%h/%h exp=1/%h/%h", n, bus.Valid, bus.DataO, bus.ErrLane, e.data, e.lane); end
    end
    go_idle();
    @(posedge clk); #1;
    checks++; if (bus.Valid !== 1'b0) begin fails++; $display("FAIL b2b_end got=%b exp=0", bus.Valid); end
  endtask

  task automatic test_chip_en();
    @(negedge clk);
    bus.ChipEn = 1'b0; bus.Read = 1'b1; bus.Addr = 10'h3FF;
    #1;
    checks++; if (bus.DataO !== 32'h0 || bus.Valid !== 1'b0) begin
      fails++; $display("FAIL ce_comb got=%h/%b exp=0/0", bus.DataO, bus.Valid); end
    @(posedge clk); #1;
    checks++; if (bus.DataO !== 32'h0 || bus.Valid !== 1'b0 || bus.ErrCnt !== 2'd1 || bus.ParityErr !== 1'b0) begin
      fails++; $display("FAIL ce_edge got=%h/%b/%0d/%b exp=0/0/1/0", bus.DataO, bus.Valid, bus.ErrCnt, bus.ParityErr); end
    go_idle();
    bus.ChipEn = 1'b1;
    #1;
    checks++; if (bus.DataO !== 32'hDEADBEEF) begin fails++; $display("FAIL ce_restore got=%h exp=deadbeef", bus.DataO); end
  endtask

  task automatic test_reset_mid_read();
    exp_t e;
    int   vseen = 0;
    @(negedge clk);
    bus.Read = 1'b1; bus.Addr = 10'h3FF;
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.DataO !== 32'h0 || bus.ErrCnt !== 2'd0 || bus.ErrAddr !== 10'h0) begin
      fails++; $display("FAIL rstm_async got=%h/%0d/%h exp=0/0/0", bus.DataO, bus.ErrCnt, bus.ErrAddr); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.Valid !== 1'b0) vseen++;
      if (c == 0) go_idle();
      @(negedge clk);
      if (c == 1) rst = 1'b0;
    end
    checks++; if (vseen != 0 || bus.ErrCnt !== 2'd0 || bus.ErrOvf !== 1'b0 || bus.ErrLane !== 4'h0) begin
      fails++; $display("FAIL rstm_quiet got=%0d/%0d/%b/%h exp=0/0/0/0", vseen, bus.ErrCnt, bus.ErrOvf, bus.ErrLane); end
    rd(10'h005, 1'b0);
    e = sb.pop_front();
    checks++; if (bus.Valid !== 1'b1 || bus.DataO !== e.data || bus.DataO !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rstm_mem got=%b/%h exp=1/deadbeef", bus.Valid, bus.DataO); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_byte_en();
    test_inject();
    test_saturate();
    test_rw_conflict();
    test_back_to_back();
    test_chip_en();
    test_reset_mid_read();
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
